hazard_controller: RTL and testbench
====================================

# hazard_controller

ID-stage hazard and redirect controller for the five-stage pipeline. It is the consuming end of the fetch interface. It reads the instruction held in IF/ID and the destination info of the instruction in EX. It drives the fetch-side controls back to PC and IF/ID: `holdPC`, IF/ID hold, `flush`, `PCsrc` and `isBranch`. It resolves load-use and branch-operand hazards with a small stall FSM, and it squashes the wrong-path fetch on taken branches and jumps.

## Interface
Parameters:
- `NOP_INST`, default 32'h0000_0000: instruction word treated as a bubble, which has no hazards.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `id_inst`  input  32  instruction from IF/ID `inst_out`.
- `id_regs_equal`  input  1  ID comparator result, rs value == rt value (after forwarding).
- `ex_mem_read`  input  1  instruction in EX is a load.
- `ex_reg_write`  input  1  instruction in EX writes a register.
- `ex_dst`  input  5  destination register of the instruction in EX.
- `holdPC`  output  1  PC keeps its value.
- `hold_if_id`  output  1  IF/ID keeps its contents.
- `bubble`  output  1  ID/EX loads zero control.
- `flush`  output  1  IF/ID loads `NOP_INST` at the next edge.
- `PCsrc`  output  1  PC takes the jump target (`jVal`).
- `isBranch`  output  1  PC takes PC+4+`PCoffset`.
- `jump_reg`  output  1  jump target comes from rs (jr) rather than the immediate.

## Operation
- Decode fields: op = `id_inst`[31:26], rs = [25:21], rt = [20:16], funct = [5:0].
- rs is used by every opcode except j (000010) and jal (000011).
- rt is used by R-type (000000), beq (000100), bne (000101) and sw (101011).
- A register equal to 0 never matches.
- A `NOP_INST` word uses no registers.
- `match` = `ex_dst` != 0 and `ex_dst` equals a used rs or rt.
- Control instruction (ctl): beq, bne, or jr (op 0, funct 001000).
- Stall need, evaluated in state RUN:
  - need 2: ctl and `ex_mem_read` and `match`.
  - need 1: (not ctl, `ex_mem_read`, `match`) or (ctl, `ex_reg_write`, not `ex_mem_read`, `match`).
  - need 0: otherwise.
- FSM states:
  - RUN:
    - need 0: no stall; evaluate redirect.
    - need 1: stall this cycle; stay in RUN.
    - need 2: stall this cycle; go to HOLD.
  - HOLD: stall this cycle unconditionally (the load is now in MEM and is not visible on the EX inputs). Return to RUN at the next edge.
- Stall cycle: `holdPC` = `hold_if_id` = `bubble` = 1. `flush`, `PCsrc`, `isBranch` and `jump_reg` are all 0. Stall has priority over redirect.
- Redirect (RUN, need 0):
  - beq with `id_regs_equal` = 1, or bne with `id_regs_equal` = 0: `isBranch` = 1, `flush` = 1.
  - j or jal: `PCsrc` = 1, `flush` = 1.
  - jr: `PCsrc` = 1, `jump_reg` = 1, `flush` = 1.
  - Not-taken branch: all outputs 0.
- `PCsrc` and `isBranch` are never both 1.

## Timing
- All outputs are combinational from the current state plus the inputs, valid in the same cycle. State updates on the `clk` rising edge.
- Reset: while `rst` = 1, every output is forced to 0. State goes to RUN at the edge.
- Reset mid-HOLD: return to RUN, and the pending second stall is discarded.
- Branch penalty: 1 cycle when taken (the squashed fetch).
- Load-use penalty: 1 cycle.
- Branch dependent on an ALU result in EX: 1 cycle.
- Branch dependent on a load in EX: 2 cycles.
- The instruction after a flush arrives as `NOP_INST`. It produces need 0 and no redirect.
- Back-to-back control instructions: each one is evaluated independently once it is in RUN with need 0.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: adds outputs `stall_cycles` (32-bit) and `flush_cycles` (32-bit). These are saturating counters, incremented on every cycle with a stall or a flush respectively, and cleared by `rst`.
  - Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Load-use: EX = lw $8 (`ex_mem_read`=1, `ex_dst`=8); ID = add $9,$8,$1.
  - Required: one cycle of `holdPC`=`hold_if_id`=`bubble`=1, then all 0.
- Load then branch: EX = lw $4; ID = beq $4,$5.
  - Required: 2 stall cycles (RUN→HOLD→RUN).
  - Next cycle with `id_regs_equal`=1: `isBranch`=1, `flush`=1.
- Branch after ALU: EX writes $3 (`ex_reg_write`=1); ID = bne $3,$0 with `id_regs_equal`=0.
  - Required: 1 stall cycle, then `isBranch`=1, `flush`=1.
- Jumps with no dependence:
  - ID = j 0x40: `PCsrc`=1, `flush`=1, `jump_reg`=0.
  - ID = jr $31: `PCsrc`=1, `jump_reg`=1.
- Reset in HOLD: assert `rst` in the HOLD cycle.
  - Required: outputs 0 that cycle; the FSM is in RUN next cycle with no further stall.
- `$0` destination: EX lw with `ex_dst`=0; ID uses $0.
  - Required: no stall.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage hazard and redirect controller.
// It decodes the IF/ID instruction and checks it against the destination of
// the instruction in EX. From that it stalls load-use and branch-operand
// hazards, and it squashes the wrong-path fetch on taken branches and jumps.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_controller #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_regs_equal,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dst,
  output logic        holdPC,
  output logic        hold_if_id,
  output logic        bubble,
  output logic        flush,
  output logic        PCsrc,
  output logic        isBranch,
  output logic        jump_reg
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       is_nop;
  logic       is_beq;
  logic       is_bne;
  logic       is_jump;
  logic       is_jr;
  logic       is_ctl;
  logic       uses_rs;
  logic       uses_rt;
  logic       match;
  logic       need_two;
  logic       need_one;
  logic       stall;

  assign op     = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign funct  = id_inst[5:0];
  // A bubble word carries no hazards and never redirects, whatever it decodes to.
  assign is_nop = (id_inst == NOP_INST);

  assign is_beq  = !is_nop && (op == OP_BEQ);
  assign is_bne  = !is_nop && (op == OP_BNE);
  assign is_jump = !is_nop && ((op == OP_J) || (op == OP_JAL));
  assign is_jr   = !is_nop && (op == OP_RTYPE) && (funct == FN_JR);
  assign is_ctl  = is_beq || is_bne || is_jr;

  assign uses_rs = !is_nop && (op != OP_J) && (op != OP_JAL);
  assign uses_rt = !is_nop && ((op == OP_RTYPE) || (op == OP_BEQ) ||
                               (op == OP_BNE) || (op == OP_SW));

  // $0 is hardwired, so a zero destination can never create a dependence.
  assign match = (ex_dst != 5'd0) &&
                 ((uses_rs && (rs == ex_dst)) || (uses_rt && (rt == ex_dst)));

  // Branches read operands in ID, so a load ahead of them costs two cycles
  // and an ALU result costs one; ordinary consumers only wait on loads.
  assign need_two = is_ctl && ex_mem_read && match;
  assign need_one = (!is_ctl && ex_mem_read && match) ||
                    (is_ctl && ex_reg_write && !ex_mem_read && match);

  assign stall = !rst && ((state_q == ST_HOLD) || need_two || need_one);

  // State register with synchronous reset back to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter HOLD only for the second cycle of a load-to-branch stall.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:  state_d = need_two ? ST_HOLD : ST_RUN;
      ST_HOLD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs: stall beats redirect; reset forces everything low.
  always_comb begin
    holdPC     = 1'b0;
    hold_if_id = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    PCsrc      = 1'b0;
    isBranch   = 1'b0;
    jump_reg   = 1'b0;
    if (rst) begin
      holdPC = 1'b0;
    end else if (stall) begin
      holdPC     = 1'b1;
      hold_if_id = 1'b1;
      bubble     = 1'b1;
    end else if ((is_beq && id_regs_equal) || (is_bne && !id_regs_equal)) begin
      isBranch = 1'b1;
      flush    = 1'b1;
    end else if (is_jump) begin
      PCsrc = 1'b1;
      flush = 1'b1;
    end else if (is_jr) begin
      PCsrc    = 1'b1;
      jump_reg = 1'b1;
      flush    = 1'b1;
    end else begin
      flush = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (holdPC && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed test-plan cases followed
// by random instruction streams compared against a stall-budget reference model.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst;
  logic        id_regs_equal;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_dst;
  logic        holdPC, hold_if_id, bubble, flush, PCsrc, isBranch, jump_reg;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_cycles;
  int unsigned exp_stalls = 0;
  int unsigned exp_flushes = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pending  = 0;   // stall cycles still owed by the model

  // Output vector order: {holdPC, hold_if_id, bubble, flush, PCsrc, isBranch, jump_reg}
  localparam logic [6:0] E_NONE  = 7'b000_0000;
  localparam logic [6:0] E_STALL = 7'b111_0000;
  localparam logic [6:0] E_BR    = 7'b000_1010;
  localparam logic [6:0] E_J     = 7'b000_1100;
  localparam logic [6:0] E_JR    = 7'b000_1101;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_regs_equal(id_regs_equal),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .holdPC(holdPC), .hold_if_id(hold_if_id), .bubble(bubble), .flush(flush),
    .PCsrc(PCsrc), .isBranch(isBranch), .jump_reg(jump_reg)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // outputs just after, and account the cycle in the counter model.
  task automatic step(input string tag, input logic [31:0] inst, input logic eq,
                      input logic mr, input logic rw, input logic [4:0] dst,
                      input logic r, input logic [6:0] exp);
    @(negedge clk);
    id_inst = inst; id_regs_equal = eq; ex_mem_read = mr;
    ex_reg_write = rw; ex_dst = dst; rst = r;
    #1;
    check_eq(tag, {25'd0, holdPC, hold_if_id, bubble, flush, PCsrc, isBranch, jump_reg},
             {25'd0, exp});
`ifdef HAZARD_STATS_EN
    check_eq({tag, "_stall_cnt"}, stall_cycles, exp_stalls);
    check_eq({tag, "_flush_cnt"}, flush_cycles, exp_flushes);
    if (r) begin
      exp_stalls = 0; exp_flushes = 0;
    end else begin
      if (exp[6]) exp_stalls++;
      if (exp[3]) exp_flushes++;
    end
`endif
  endtask

  // Stall cycles an instruction in ID needs against the EX instruction.
  function automatic int model_need(input logic [31:0] inst, input logic mr,
                                    input logic rw, input logic [4:0] dst);
    int op, rs, rt, fn;
    bit ctl, hit;
    bit [4:0] used[$];
    if (inst == 32'd0) return 0;
    op = int'(inst[31:26]); rs = int'(inst[25:21]);
    rt = int'(inst[20:16]); fn = int'(inst[5:0]);
    if (op != 2 && op != 3) used.push_back(inst[25:21]);
    if (op == 0 || op == 4 || op == 5 || op == 43) used.push_back(inst[20:16]);
    hit = 1'b0;
    foreach (used[k]) if (used[k] != 0 && used[k] == dst) hit = 1'b1;
    ctl = (op == 4) || (op == 5) || (op == 0 && fn == 8);
    if (!hit) return 0;
    if (ctl && mr) return 2;
    if (!ctl && mr) return 1;
    if (ctl && rw) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] model_redirect(input logic [31:0] inst, input logic eq);
    int op, fn;
    if (inst == 32'd0) return E_NONE;
    op = int'(inst[31:26]); fn = int'(inst[5:0]);
    if ((op == 4 && eq) || (op == 5 && !eq)) return E_BR;
    if (op == 2 || op == 3) return E_J;
    if (op == 0 && fn == 8) return E_JR;
    return E_NONE;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops[8];
    logic [5:0] fns[4];
    logic [31:0] w;
    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};
    fns = '{6'd8, 6'd32, 6'd0, 6'd42};
    if ($urandom_range(0, 9) == 0) return 32'd0;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[5:0]   = fns[$urandom_range(0, 3)];
    return w;
  endfunction

  logic [31:0] add_9_8_1, add_9_0_0, beq_4_5, bne_3_0, j_40, jal_80, jr_31;

  initial begin
    add_9_8_1 = {6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'd32};
    add_9_0_0 = {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'd32};
    beq_4_5   = {6'd4, 5'd4, 5'd5, 16'd0};
    bne_3_0   = {6'd5, 5'd3, 5'd0, 16'd0};
    j_40      = {6'd2, 26'h40};
    jal_80    = {6'd3, 26'h80};
    jr_31     = {6'd0, 5'd31, 15'd0, 6'd8};
    rst = 1'b1; id_inst = 32'd0; id_regs_equal = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;

    // Reset, with a hazard-looking input that must still give all zeros.
    step("reset0", add_9_8_1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, E_NONE);
    step("reset1", 32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_NONE);

    // Load-use: one stall cycle.
    step("ldu_stall", add_9_8_1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, E_STALL);
    step("ldu_go",    add_9_8_1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_NONE);

    // Load then branch: two stalls, second one with EX already a bubble.
    step("ldbr_s1",   beq_4_5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, E_STALL);
    step("ldbr_s2",   beq_4_5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_STALL);
    step("ldbr_take", beq_4_5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_BR);
    step("after_fl",  32'd0,   1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_NONE);

    // Branch after ALU: one stall then taken bne.
    step("alubr_s",    bne_3_0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, E_STALL);
    step("alubr_take", bne_3_0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_BR);

    // Jumps back to back, no dependence.
    step("j",   j_40,   1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_J);
    step("jal", jal_80, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, E_J);
    step("jr",  jr_31,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_JR);
    step("jr_dep", jr_31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, E_STALL);
    step("jr_dep2", jr_31, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_STALL);
    step("jr_go", jr_31, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_JR);

    // Reset in HOLD discards the second stall.
    step("rh_s1",  beq_4_5, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, E_STALL);
    step("rh_rst", beq_4_5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_NONE);
    step("rh_run", beq_4_5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_NONE);

    // $0 destination never matches; not-taken beq gives nothing.
    step("zero_dst", add_9_0_0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, E_NONE);
    step("beq_nt",   beq_4_5,   1'b0, 1'b0, 1'b1, 5'd9, 1'b0, E_NONE);

    // Random stream against the stall-budget model.
    step("rnd_rst", 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_NONE);
    pending = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      logic eq, mr, rw, r;
      logic [4:0] dst;
      logic [6:0] exp;
      int need;
      inst = rand_inst();
      eq   = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 2) == 0);
      rw   = mr | 1'($urandom_range(0, 1));
      dst  = 5'($urandom_range(0, 3));
      r    = 1'($urandom_range(0, 29) == 0);
      if (r) begin
        exp = E_NONE; pending = 0;
      end else if (pending > 0) begin
        exp = E_STALL; pending--;
      end else begin
        need = model_need(inst, mr, rw, dst);
        if (need > 0) begin
          exp = E_STALL; pending = need - 1;
        end else begin
          exp = model_redirect(inst, eq);
        end
      end
      step("rnd", inst, eq, mr, rw, dst, r, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
